// File: rtl/npu_dispatch_scheduler.sv
// In-order dispatch scheduler: buffers decoded NPU instructions and issues them
// to compute/memory/vector/elementwise units with busy and RAW/WAW interlocks.
`timescale 1ns/1ps

package npu_dispatch_pkg;
  typedef enum logic [4:0] {
    OP_NOP    = 5'd0,
    OP_CONV   = 5'd1,
    OP_MATMUL = 5'd2,
    OP_LOAD   = 5'd3,
    OP_STORE  = 5'd4,
    OP_RELU   = 5'd5,
    OP_POOL   = 5'd6,
    OP_ADD    = 5'd7,
    OP_MUL    = 5'd8,
    OP_SYNC   = 5'd9
  } opcode_t;
endpackage

module npu_dispatch_scheduler
  import npu_dispatch_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int IMM_W      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            dec_valid,
  input  logic                            dec_error,
  input  opcode_t                         dec_opcode,
  input  logic                            dec_is_compute,
  input  logic                            dec_is_memory,
  input  logic                            dec_is_activation,
  input  logic                            dec_is_pooling,
  input  logic                            dec_is_elementwise,
  input  logic                            dec_is_sync,
  input  logic [7:0]                      dec_dst,
  input  logic [7:0]                      dec_src0,
  input  logic [7:0]                      dec_src1,
  input  logic [IMM_W-1:0]                dec_imm,
  output logic [3:0]                      iss_valid,
  input  logic [3:0]                      iss_ready,
  output opcode_t                         iss_opcode,
  output logic [7:0]                      iss_dst,
  output logic [7:0]                      iss_src0,
  output logic [7:0]                      iss_src1,
  output logic [IMM_W-1:0]                iss_imm,
  input  logic [3:0]                      unit_done,
  output logic [3:0]                      unit_busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            fifo_full,
  output logic                            overflow,
  output logic                            err_drop,
  output logic                            sync_done,
  output logic                            idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    opcode_t          opcode;
    logic             is_compute;
    logic             is_memory;
    logic             is_vector;
    logic             is_elementwise;
    logic             is_sync;
    logic [7:0]       dst;
    logic [7:0]       src0;
    logic [7:0]       src1;
    logic [IMM_W-1:0] imm;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_ISSUE, S_SYNC} state_t;

  entry_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q, err_drop_q, sync_done_q;
  state_t            state_q;
  logic [3:0]        iss_valid_q;
  opcode_t           iss_opcode_q;
  logic [7:0]        iss_dst_q, iss_src0_q, iss_src1_q;
  logic [IMM_W-1:0]  iss_imm_q;
  logic [3:0]        busy_q, busy_d;
  logic [7:0]        dst_q [4];

  entry_t            wr_entry_s, head_s;
  logic              full_s, empty_s, push_s, pop_s, issue_s, accept_s, hazard_s, decide_s;
  logic [3:0]        tgt_s;

  assign wr_entry_s = '{opcode: dec_opcode, is_compute: dec_is_compute, is_memory: dec_is_memory,
                        is_vector: dec_is_activation | dec_is_pooling,
                        is_elementwise: dec_is_elementwise, is_sync: dec_is_sync,
                        dst: dec_dst, src0: dec_src0, src1: dec_src1, imm: dec_imm};

  assign head_s   = mem_q[rd_ptr_q];
  assign full_s   = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_s  = (count_q == '0);
  // Fullness is sampled before any same-cycle pop, so a write on a full FIFO is lost.
  assign push_s   = dec_valid && !dec_error && !full_s;
  assign decide_s = ((state_q == S_IDLE) || (state_q == S_DECIDE)) && !empty_s;
  assign accept_s = (state_q == S_ISSUE) && ((iss_valid_q & iss_ready) != 4'b0000);

  always_comb begin
    tgt_s = 4'b0000;
    if (head_s.is_compute)          tgt_s = 4'b0001;
    else if (head_s.is_memory)      tgt_s = 4'b0010;
    else if (head_s.is_vector)      tgt_s = 4'b0100;
    else if (head_s.is_elementwise) tgt_s = 4'b1000;
    else                            tgt_s = 4'b0000;
  end

  always_comb begin
    hazard_s = 1'b0;
    for (int u = 0; u < 4; u++) begin
      hazard_s = hazard_s | (busy_q[u] && ((dst_q[u] == head_s.src0) ||
                                          (dst_q[u] == head_s.src1) ||
                                          (dst_q[u] == head_s.dst)));
    end
  end

  always_comb begin
    pop_s   = 1'b0;
    issue_s = 1'b0;
    if (decide_s) begin
      if (head_s.is_sync || (tgt_s == 4'b0000)) begin
        pop_s = 1'b1;
      end else if (((tgt_s & busy_q) == 4'b0000) && !hazard_s) begin
        pop_s   = 1'b1;
        issue_s = 1'b1;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= wr_entry_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (dec_valid && dec_error)            err_drop_q <= 1'b1;
      if (dec_valid && !dec_error && full_s) overflow_q <= 1'b1;
    end
  end

  // A unit accepted this cycle becomes busy even if a stray done pulse arrives with it.
  always_comb begin
    busy_d = busy_q & ~unit_done;
    if (accept_s) busy_d = busy_d | iss_valid_q;
    else          busy_d = busy_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      for (int u = 0; u < 4; u++) dst_q[u] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int u = 0; u < 4; u++) begin
        if (accept_s && iss_valid_q[u]) dst_q[u] <= iss_dst_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      iss_valid_q  <= '0;
      iss_opcode_q <= OP_NOP;
      iss_dst_q    <= '0;
      iss_src0_q   <= '0;
      iss_src1_q   <= '0;
      iss_imm_q    <= '0;
      sync_done_q  <= 1'b0;
    end else begin
      sync_done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DECIDE: begin
          if (empty_s) begin
            state_q <= S_IDLE;
          end else if (head_s.is_sync) begin
            state_q <= S_SYNC;
          end else if (issue_s) begin
            state_q      <= S_ISSUE;
            iss_valid_q  <= tgt_s;
            iss_opcode_q <= head_s.opcode;
            iss_dst_q    <= head_s.dst;
            iss_src0_q   <= head_s.src0;
            iss_src1_q   <= head_s.src1;
            iss_imm_q    <= head_s.imm;
          end else begin
            state_q <= S_DECIDE;
          end
        end
        S_ISSUE: begin
          if (accept_s) begin
            iss_valid_q <= '0;
            state_q     <= empty_s ? S_IDLE : S_DECIDE;
          end
        end
        // Retire as soon as the last outstanding done pulse is seen.
        S_SYNC: begin
          if (busy_d == 4'b0000) begin
            sync_done_q <= 1'b1;
            state_q     <= empty_s ? S_IDLE : S_DECIDE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign iss_valid  = iss_valid_q;
  assign iss_opcode = iss_opcode_q;
  assign iss_dst    = iss_dst_q;
  assign iss_src0   = iss_src0_q;
  assign iss_src1   = iss_src1_q;
  assign iss_imm    = iss_imm_q;
  assign unit_busy  = busy_q;
  assign fifo_count = count_q;
  assign fifo_full  = full_s;
  assign overflow   = overflow_q;
  assign err_drop   = err_drop_q;
  assign sync_done  = sync_done_q;
  assign idle       = empty_s && (busy_q == 4'b0000) && (iss_valid_q == 4'b0000) && (state_q != S_SYNC);

endmodule

// File: tb/tb_npu_dispatch_scheduler.sv
// Scoreboard bench for npu_dispatch_scheduler: expected issues are queued at
// enqueue time and matched against every accepted issue in order.
`timescale 1ns/1ps

module tb_npu_dispatch_scheduler;
  import npu_dispatch_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam int IMM_W      = 32;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             dec_valid, dec_error;
  opcode_t          dec_opcode;
  logic             dec_is_compute, dec_is_memory, dec_is_activation;
  logic             dec_is_pooling, dec_is_elementwise, dec_is_sync;
  logic [7:0]       dec_dst, dec_src0, dec_src1;
  logic [IMM_W-1:0] dec_imm;
  logic [3:0]       iss_valid, iss_ready, unit_done, unit_busy;
  opcode_t          iss_opcode;
  logic [7:0]       iss_dst, iss_src0, iss_src1;
  logic [IMM_W-1:0] iss_imm;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, overflow, err_drop, sync_done, idle;

  npu_dispatch_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_error(dec_error), .dec_opcode(dec_opcode),
    .dec_is_compute(dec_is_compute), .dec_is_memory(dec_is_memory),
    .dec_is_activation(dec_is_activation), .dec_is_pooling(dec_is_pooling),
    .dec_is_elementwise(dec_is_elementwise), .dec_is_sync(dec_is_sync),
    .dec_dst(dec_dst), .dec_src0(dec_src0), .dec_src1(dec_src1), .dec_imm(dec_imm),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
    .iss_dst(iss_dst), .iss_src0(iss_src0), .iss_src1(iss_src1), .iss_imm(iss_imm),
    .unit_done(unit_done), .unit_busy(unit_busy),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .overflow(overflow),
    .err_drop(err_drop), .sync_done(sync_done), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       unit;
    opcode_t          op;
    logic [7:0]       dst;
    logic [7:0]       src0;
    logic [7:0]       src1;
    logic [IMM_W-1:0] imm;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         rel, n_issued, n_sync, sync_cyc, n_before;
  int         first_valid[4];
  logic [3:0] prev_valid, acc_last;
  bit         auto_done;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] unit_of(input opcode_t op);
    case (op)
      OP_CONV, OP_MATMUL: return 4'b0001;
      OP_LOAD, OP_STORE:  return 4'b0010;
      OP_RELU, OP_POOL:   return 4'b0100;
      OP_ADD, OP_MUL:     return 4'b1000;
      default:            return 4'b0000;
    endcase
  endfunction

  task automatic send(input opcode_t op, input logic [7:0] d, input logic [7:0] s0,
                      input logic [7:0] s1, input logic [IMM_W-1:0] imm,
                      input bit err, input bit expect_issue);
    dec_valid          = 1'b1;
    dec_error          = err;
    dec_opcode         = op;
    dec_is_compute     = (op == OP_CONV) || (op == OP_MATMUL);
    dec_is_memory      = (op == OP_LOAD) || (op == OP_STORE);
    dec_is_activation  = (op == OP_RELU);
    dec_is_pooling     = (op == OP_POOL);
    dec_is_elementwise = (op == OP_ADD) || (op == OP_MUL);
    dec_is_sync        = (op == OP_SYNC);
    dec_dst  = d;
    dec_src0 = s0;
    dec_src1 = s1;
    dec_imm  = imm;
    if (expect_issue) exp_q.push_back('{unit: unit_of(op), op: op, dst: d, src0: s0, src1: s1, imm: imm});
  endtask

  // Samples outputs mid-cycle and retires accepted issues against the queue.
  task automatic sample();
    logic [3:0] acc;
    exp_t       e;
    @(negedge clk);
    acc = 4'b0000;
    if (!rst) begin
      for (int u = 0; u < 4; u++)
        if (iss_valid[u] && !prev_valid[u] && first_valid[u] < 0) first_valid[u] = rel;
      if (iss_valid != 4'b0000) check_eq("iss_onehot", 64'($countones(iss_valid)), 64'd1);
      acc = iss_valid & iss_ready;
      if (acc != 4'b0000) begin
        n_issued++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_issue", 64'(acc), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("iss_unit", 64'(acc), 64'(e.unit));
          check_eq("iss_opcode", 64'(iss_opcode), 64'(e.op));
          check_eq("iss_dst", 64'(iss_dst), 64'(e.dst));
          check_eq("iss_src0", 64'(iss_src0), 64'(e.src0));
          check_eq("iss_src1", 64'(iss_src1), 64'(e.src1));
          check_eq("iss_imm", 64'(iss_imm), 64'(e.imm));
        end
      end
      if (sync_done) begin
        n_sync++;
        sync_cyc = rel;
      end
    end
    acc_last   = acc;
    prev_valid = rst ? 4'b0000 : iss_valid;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    rel++;
    dec_valid = 1'b0;
    dec_error = 1'b0;
    unit_done = auto_done ? acc_last : 4'b0000;
  endtask

  task automatic clear_scen();
    rel = 0; n_issued = 0; n_sync = 0; sync_cyc = -1;
    prev_valid = 4'b0000; acc_last = 4'b0000;
    foreach (first_valid[u]) first_valid[u] = -1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    dec_valid = 1'b0; dec_error = 1'b0; dec_opcode = OP_NOP;
    dec_is_compute = 1'b0; dec_is_memory = 1'b0; dec_is_activation = 1'b0;
    dec_is_pooling = 1'b0; dec_is_elementwise = 1'b0; dec_is_sync = 1'b0;
    dec_dst = 8'h00; dec_src0 = 8'h00; dec_src1 = 8'h00; dec_imm = 32'h0;
    unit_done = 4'b0000; iss_ready = 4'b1111; auto_done = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_scen();
  endtask

  task automatic check_reset_vals(input string p);
    check_eq({p, "_iss_valid"}, 64'(iss_valid), 64'd0);
    check_eq({p, "_iss_opcode"}, 64'(iss_opcode), 64'(OP_NOP));
    check_eq({p, "_payload"}, {iss_dst, iss_src0, iss_src1, iss_imm}, 64'd0);
    check_eq({p, "_unit_busy"}, 64'(unit_busy), 64'd0);
    check_eq({p, "_fifo_count"}, 64'(fifo_count), 64'd0);
    check_eq({p, "_flags"}, {60'd0, fifo_full, overflow, err_drop, sync_done}, 64'd0);
    check_eq({p, "_idle"}, 64'(idle), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single compute instruction with a late done pulse.
    reset_dut();
    for (int k = 0; k < 10; k++) begin
      if (k == 0) send(OP_CONV, 8'h10, 8'h01, 8'h02, 32'hC0DE_0001, 1'b0, 1'b1);
      if (k == 5) unit_done = 4'b0001;
      sample();
      case (k)
        0: check_reset_vals("t1_rst");
        1: check_eq("t1_valid_c1", 64'(iss_valid), 64'd0);
        2: check_eq("t1_valid_c2", 64'(iss_valid), 64'b0001);
        3: check_eq("t1_busy_c3", 64'(unit_busy), 64'b0001);
        5: check_eq("t1_busy_c5", 64'(unit_busy), 64'b0001);
        6: check_eq("t1_busy_c6", 64'(unit_busy), 64'd0);
        7: check_eq("t1_idle_c7", 64'(idle), 64'd1);
        default: ;
      endcase
      advance();
    end
    check_eq("t1_drained", 64'(exp_q.size()), 64'd0);

    // RAW hazard: ADD reads the LOAD destination.
    reset_dut();
    for (int k = 0; k < 16; k++) begin
      if (k == 0)  send(OP_LOAD, 8'h20, 8'h05, 8'h06, 32'h0000_0020, 1'b0, 1'b1);
      if (k == 1)  send(OP_ADD, 8'h30, 8'h20, 8'h07, 32'h0000_0030, 1'b0, 1'b1);
      if (k == 10) unit_done = 4'b0010;
      sample();
      case (k)
        3:  check_eq("t2_busy_c3", 64'(unit_busy), 64'b0010);
        9:  check_eq("t2_count_c9", 64'(fifo_count), 64'd1);
        11: check_eq("t2_busy_c11", 64'(unit_busy), 64'd0);
        default: ;
      endcase
      advance();
    end
    check_eq("t2_load_first", 64'(first_valid[1]), 64'd2);
    check_eq("t2_add_first", 64'(first_valid[3]), 64'd12);
    check_eq("t2_drained", 64'(exp_q.size()), 64'd0);

    // SYNC barrier drains compute and vector before STORE.
    reset_dut();
    for (int k = 0; k < 20; k++) begin
      case (k)
        0: send(OP_CONV, 8'h40, 8'h01, 8'h02, 32'h0000_0040, 1'b0, 1'b1);
        1: send(OP_POOL, 8'h41, 8'h50, 8'h51, 32'h0000_0041, 1'b0, 1'b1);
        2: send(OP_SYNC, 8'h00, 8'h00, 8'h00, 32'h0, 1'b0, 1'b0);
        3: send(OP_STORE, 8'h60, 8'h61, 8'h62, 32'h0000_0060, 1'b0, 1'b1);
        8: unit_done = 4'b0001;
        12: unit_done = 4'b0100;
        default: ;
      endcase
      sample();
      advance();
    end
    check_eq("t3_conv_first", 64'(first_valid[0]), 64'd2);
    check_eq("t3_pool_first", 64'(first_valid[2]), 64'd4);
    check_eq("t3_sync_cycle", 64'(sync_cyc), 64'd13);
    check_eq("t3_sync_count", 64'(n_sync), 64'd1);
    check_eq("t3_store_first", 64'(first_valid[1]), 64'd14);
    check_eq("t3_drained", 64'(exp_q.size()), 64'd0);

    // Overflow: head stalled on a busy unit while 10 instructions arrive.
    reset_dut();
    n_before = 0;
    for (int k = 0; k < 60; k++) begin
      if (k == 0) send(OP_CONV, 8'h70, 8'h71, 8'h72, 32'h0000_0070, 1'b0, 1'b1);
      if (k == 3) iss_ready = 4'b0000;
      if (k >= 3 && k <= 12)
        send(OP_MATMUL, 8'h80 + 8'(k - 3), 8'h90 + 8'(k - 3), 8'hA0 + 8'(k - 3),
             32'h1000 + 32'(k - 3), 1'b0, (k - 3) < 8);
      if (k == 14) begin
        iss_ready = 4'b1111;
        auto_done = 1'b1;
        unit_done = 4'b0001;
        n_before  = n_issued;
      end
      if (k == 15) send(OP_MUL, 8'hF0, 8'hF1, 8'hF2, 32'h0, 1'b0, 1'b0);
      sample();
      case (k)
        10: check_eq("t4_full_c10", 64'(fifo_full), 64'd0);
        11: check_eq("t4_ovf_c11", 64'(overflow), 64'd0);
        12: check_eq("t4_ovf_c12", 64'(overflow), 64'd1);
        13: check_eq("t4_count_c13", {fifo_full, 63'(fifo_count)}, {1'b1, 63'd8});
        15: check_eq("t4_full_c15", 64'(fifo_full), 64'd1);
        16: check_eq("t4_count_c16", 64'(fifo_count), 64'd7);
        default: ;
      endcase
      advance();
    end
    check_eq("t4_issued_after", 64'(n_issued - n_before), 64'd8);
    check_eq("t4_err_drop", 64'(err_drop), 64'd0);
    check_eq("t4_idle", {idle, 63'(fifo_count)}, {1'b1, 63'd0});
    check_eq("t4_drained", 64'(exp_q.size()), 64'd0);

    // Error drop: flagged instruction never enters the FIFO.
    reset_dut();
    for (int k = 0; k < 8; k++) begin
      if (k == 0) send(OP_ADD, 8'h11, 8'h12, 8'h13, 32'h0000_0011, 1'b1, 1'b0);
      sample();
      case (k)
        0: check_eq("t5_err_c0", 64'(err_drop), 64'd0);
        1: check_eq("t5_err_c1", {err_drop, 63'(fifo_count)}, {1'b1, 63'd0});
        2: check_eq("t5_ovf_c2", 64'(overflow), 64'd0);
        default: ;
      endcase
      advance();
    end
    check_eq("t5_no_issue", 64'(n_issued), 64'd0);
    check_eq("t5_sticky_idle", {err_drop, idle}, 64'b11);

    // Reset while an issue is pending and three entries are queued.
    reset_dut();
    iss_ready = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: send(OP_POOL, 8'h21, 8'h22, 8'h23, 32'h0000_0021, 1'b0, 1'b1);
        1: send(OP_ADD,  8'h24, 8'h25, 8'h26, 32'h0000_0024, 1'b0, 1'b1);
        2: send(OP_LOAD, 8'h27, 8'h28, 8'h29, 32'h0000_0027, 1'b0, 1'b1);
        3: send(OP_RELU, 8'h2A, 8'h2B, 8'h2C, 32'h0000_002A, 1'b0, 1'b1);
        default: ;
      endcase
      sample();
      if (k == 4) check_eq("t6_pre_state", {iss_valid, 60'(fifo_count)}, {4'b0100, 60'd3});
      advance();
    end
    rst = 1'b1;
    unit_done = 4'b1111;
    sample();
    check_reset_vals("t6_rst");
    advance();
    unit_done = 4'b0100;
    rst = 1'b0;
    iss_ready = 4'b1111;
    exp_q.delete();
    clear_scen();
    for (int k = 0; k < 10; k++) begin
      sample();
      advance();
    end
    check_eq("t6_no_issue", 64'(n_issued), 64'd0);
    check_eq("t6_busy", 64'(unit_busy), 64'd0);
    check_eq("t6_idle", {idle, 63'(fifo_count)}, {1'b1, 63'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
